// File: rtl/bresenham_line.sv
// bresenham_line
//   Rasterises one segment (x1,y1)->(x2,y2) into single-pixel framebuffer
//   writes with integer Bresenham. Covers all octants and single points.
//   Pixels outside the visible area are skipped without being written.
//
// Ports
//   clk          clock, all logic on posedge
//   reset        synchronous, active-high
//   start        line request, sampled only while ready=1
//   ready        1 = idle, a start is accepted
//   x1, y1       start point (unsigned), latched on the start cycle
//   x2, y2       end point (unsigned), latched on the start cycle
//   pixel_x/y    pixel coordinate, valid while pixel_write=1
//   pixel_write  pixel valid; held stable until pixel_ready
//   pixel_ready  framebuffer accepts the pixel (transfer = write & ready)
//
// state | meaning
// IDLE  | waiting for start, ready=1
// INIT  | derive dx, dy, step directions, initial error, cur=(x1,y1)
// PLOT  | present cur (or skip it if off screen); finish at the endpoint
// STEP  | advance cur by one Bresenham step
module bresenham_line #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS),
  localparam int W = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               ready,
  input  logic [X_WIDTH-1:0] x1,
  input  logic [Y_WIDTH-1:0] y1,
  input  logic [X_WIDTH-1:0] x2,
  input  logic [Y_WIDTH-1:0] y2,
  output logic [X_WIDTH-1:0] pixel_x,
  output logic [Y_WIDTH-1:0] pixel_y,
  output logic               pixel_write,
  input  logic               pixel_ready
);

  typedef enum logic [1:0] {IDLE, INIT, PLOT, STEP} state_t;

  // One extra bit so a power-of-two screen size still compares correctly.
  localparam logic [X_WIDTH:0] X_LIM = HOR_ACTIVE_PIXELS[X_WIDTH:0];
  localparam logic [Y_WIDTH:0] Y_LIM = VER_ACTIVE_PIXELS[Y_WIDTH:0];

  state_t state, state_next;

  logic [X_WIDTH-1:0] x1_q, x2_q, cur_x;
  logic [Y_WIDTH-1:0] y1_q, y2_q, cur_y;
  logic               sx_neg, sy_neg;
  logic signed [W-1:0] dx, dy, err;

  logic [X_WIDTH-1:0] adx;
  logic [Y_WIDTH-1:0] ady;
  logic signed [W-1:0] init_dx, init_dy, e2, err_step;
  logic step_x, step_y, on_screen, at_end;

  assign adx     = (x2_q >= x1_q) ? (x2_q - x1_q) : (x1_q - x2_q);
  assign ady     = (y2_q >= y1_q) ? (y2_q - y1_q) : (y1_q - y2_q);
  assign init_dx = $signed({{(W-X_WIDTH){1'b0}}, adx});
  assign init_dy = -$signed({{(W-Y_WIDTH){1'b0}}, ady});

  assign e2     = err <<< 1;
  assign step_x = (e2 >= dy);
  assign step_y = (e2 <= dx);

  // Both axis contributions fold into the error in the same cycle.
  always_comb begin
    err_step = err;
    if (step_x) err_step = err_step + dy;
    if (step_y) err_step = err_step + dx;
  end

  assign on_screen = ({1'b0, cur_x} < X_LIM) && ({1'b0, cur_y} < Y_LIM);
  assign at_end    = (cur_x == x2_q) && (cur_y == y2_q);

  assign pixel_x = cur_x;
  assign pixel_y = cur_y;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    ready       = 1'b0;
    pixel_write = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = INIT;
      end
      INIT: state_next = PLOT;
      PLOT: begin
        pixel_write = on_screen;
        // Off-screen pixels do not wait for the framebuffer.
        if (!on_screen || pixel_ready)
          state_next = at_end ? IDLE : STEP;
      end
      STEP: state_next = PLOT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x1_q   <= '0;
      y1_q   <= '0;
      x2_q   <= '0;
      y2_q   <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x1_q <= x1;
            y1_q <= y1;
            x2_q <= x2;
            y2_q <= y2;
          end
        end
        INIT: begin
          dx     <= init_dx;
          dy     <= init_dy;
          err    <= init_dx + init_dy;
          sx_neg <= !(x1_q < x2_q);
          sy_neg <= !(y1_q < y2_q);
          cur_x  <= x1_q;
          cur_y  <= y1_q;
        end
        STEP: begin
          err <= err_step;
          if (step_x) cur_x <= sx_neg ? (cur_x - 1'b1) : (cur_x + 1'b1);
          if (step_y) cur_y <= sy_neg ? (cur_y - 1'b1) : (cur_y + 1'b1);
        end
        default: ;
      endcase
    end
  end

endmodule
